// File: rtl/gpu_frame_pkg.sv
// Shared frame geometry, SDRAM word layout and pixel types.
// Both the frame writer and the frame reader import these so their frame
// layouts always match.
package gpu_frame_pkg;

  localparam int unsigned FRAME_PIXELS    = 307200;
  localparam logic [27:0] FRAME_BASE_ADDR = 28'h8000000;
  localparam int unsigned SD_WORD_BYTES   = 4;

  localparam int unsigned SD_ADDR_W = 28;
  localparam int unsigned SD_DATA_W = 32;
  localparam int unsigned PIX_CNT_W = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } frame_state_e;

  // SDRAM word layout: [31:24]=R, [23:16]=G, [15:8]=B, [7:0] unused
  function automatic rgb_t unpack_word(input logic [23:0] rgb_bits);
    rgb_t px;
    px.r = rgb_bits[23:16];
    px.g = rgb_bits[15:8];
    px.b = rgb_bits[7:0];
    return px;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO of rgb_t pixels.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push, wdata    write request and pixel (dropped if full)
//   pop            advance head (ignored if empty)
//   rdata          head entry, valid whenever !empty
//   empty, full    registered occupancy flags
//   count          number of stored entries
module pixel_fifo
  import gpu_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  rgb_t                     wdata,
  output rgb_t                     rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rgb_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  // Qualified push/pop and next occupancy
  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !empty;
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers, count and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset; only entries behind a valid count are observed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM pipelined read master that fetches one RGB frame from SDRAM and
// streams it out as valid/ready pixels.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start                      one-cycle frame request (ignored unless idle)
//   SD_read, SD_address        Avalon read request and byte address
//   waitrequest                Avalon slave stall
//   SD_rdata, SD_readdatavalid Avalon read response
//   pix_r/g/b, pix_valid       pixel stream head
//   pix_ready                  consumer accept
//   pix_last                   marks the final pixel of the frame
//   busy, finished             frame in progress / one-cycle completion pulse
module sdram_frame_reader
  import gpu_frame_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT = FRAME_PIXELS,
  parameter logic [27:0] BASE_ADDR   = FRAME_BASE_ADDR,
  parameter int unsigned ADDR_STRIDE = SD_WORD_BYTES,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 SD_read,
  output logic [SD_ADDR_W-1:0] SD_address,
  input  logic                 waitrequest,
  input  logic [SD_DATA_W-1:0] SD_rdata,
  input  logic                 SD_readdatavalid,
  output logic [7:0]           pix_r,
  output logic [7:0]           pix_g,
  output logic [7:0]           pix_b,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 finished
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PIX_CNT_W-1:0] PIX_TOTAL = PIX_CNT_W'(PIXEL_COUNT);
  localparam logic [PIX_CNT_W-1:0] LAST_IDX  = PIX_CNT_W'(PIXEL_COUNT - 1);
  localparam logic [PIX_CNT_W-1:0] CREDITS   = PIX_CNT_W'(FIFO_DEPTH);
  localparam logic [SD_ADDR_W-1:0] ADDR_STEP = SD_ADDR_W'(ADDR_STRIDE);

  frame_state_e         state;
  logic [PIX_CNT_W-1:0] issue_cnt;
  logic [PIX_CNT_W-1:0] rx_cnt;
  logic [PIX_CNT_W-1:0] out_cnt;

  logic                 accept;
  logic                 active;
  logic                 push;
  logic                 pop;
  logic                 last_pop;
  logic [PIX_CNT_W-1:0] issue_next;
  logic [PIX_CNT_W-1:0] in_use;
  logic [PIX_CNT_W-1:0] in_use_next;
  logic                 want_read;

  rgb_t                 fifo_wdata;
  rgb_t                 fifo_rdata;
  logic                 fifo_empty;
  logic                 unused_fifo_full;
  logic [FCNT_W-1:0]    fifo_count;
  logic                 unused_rdata_bits;

  assign unused_rdata_bits = ^SD_rdata[7:0];

  // Handshakes and credit accounting.
  // in_use = outstanding reads + buffered pixels; a push moves one unit from
  // outstanding to buffered, so only acceptances and pops change it.
  always_comb begin
    accept      = SD_read && !waitrequest;
    active      = (state == ISSUE) || (state == DRAIN);
    push        = SD_readdatavalid && active;
    pop         = pix_valid && pix_ready;
    last_pop    = pop && (out_cnt == LAST_IDX);
    issue_next  = issue_cnt + PIX_CNT_W'(accept);
    in_use      = issue_cnt - rx_cnt + PIX_CNT_W'(fifo_count);
    in_use_next = in_use + PIX_CNT_W'(accept) - PIX_CNT_W'(pop);
    want_read   = (issue_next < PIX_TOTAL) && (in_use_next < CREDITS);
    fifo_wdata  = unpack_word(SD_rdata[31:8]);
  end

  // Frame control FSM with registered bus and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      SD_read    <= 1'b0;
      SD_address <= BASE_ADDR;
      busy       <= 1'b0;
      finished   <= 1'b0;
      issue_cnt  <= '0;
      rx_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      finished <= 1'b0;
      if (push) begin
        rx_cnt <= rx_cnt + PIX_CNT_W'(1);
      end
      if (pop) begin
        out_cnt <= out_cnt + PIX_CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            SD_address <= BASE_ADDR;
            issue_cnt  <= '0;
            rx_cnt     <= '0;
            out_cnt    <= '0;
            busy       <= 1'b1;
            SD_read    <= (PIXEL_COUNT > 0);
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (accept) begin
            SD_address <= SD_address + ADDR_STEP;
            issue_cnt  <= issue_next;
          end
          // A stalled request must stay on the bus unchanged
          if (!(SD_read && waitrequest)) begin
            SD_read <= want_read;
          end
          if (accept && (issue_next == PIX_TOTAL)) begin
            state <= DRAIN;
          end
          if (last_pop) begin
            SD_read  <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b1;
            state    <= DONE;
          end
        end

        DRAIN: begin
          SD_read <= 1'b0;
          if (last_pop) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (unused_fifo_full),
    .count (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign pix_r     = fifo_rdata.r;
  assign pix_g     = fifo_rdata.g;
  assign pix_b     = fifo_rdata.b;
  assign pix_last  = pix_valid && (out_cnt == LAST_IDX);

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader with a 16-pixel frame and 4-deep FIFO.
// Bus model answers each read with word {i, i+1, i+2, 8'hAA}, i = word index.
module tb_sdram_frame_reader;

  localparam int          N    = 16;
  localparam int          D    = 4;
  localparam logic [27:0] BASE = 28'h8000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        SD_read;
  logic [27:0] SD_address;
  logic        waitrequest = 1'b0;
  logic [31:0] SD_rdata = 32'h0;
  logic        SD_readdatavalid = 1'b0;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_last;
  logic        busy;
  logic        finished;

  sdram_frame_reader #(
    .PIXEL_COUNT (N),
    .BASE_ADDR   (BASE),
    .ADDR_STRIDE (4),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .SD_read          (SD_read),
    .SD_address       (SD_address),
    .waitrequest      (waitrequest),
    .SD_rdata         (SD_rdata),
    .SD_readdatavalid (SD_readdatavalid),
    .pix_r            (pix_r),
    .pix_g            (pix_g),
    .pix_b            (pix_b),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_last         (pix_last),
    .busy             (busy),
    .finished         (finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_mode = 0;
  int          lat_fixed = 3;
  int          ready_mode = 0;
  int          stall_idx = 0;
  int          stall_left = 0;
  logic [27:0] acc_addr [0:63];
  int          acc_cnt = 0;
  logic [23:0] px [0:63];
  logic        px_l [0:63];
  int          pop_cnt = 0;
  int          fin_cnt = 0;
  int          max_inuse = 0;
  int          errors = 0;
  int          checks = 0;

  // Slave + consumer model: decides inputs for the coming rising edge
  always @(negedge clk) begin : bus_model
    int          lat;
    int          nd;
    logic [27:0] idx;
    logic [7:0]  b8;
    resp_t       r;
    cyc++;
    waitrequest = (stall_left > 0) && SD_read && (SD_address == BASE + 28'(stall_idx * 4));
    if (waitrequest) stall_left--;
    if (SD_read && !waitrequest) begin
      if (acc_cnt < 64) acc_addr[acc_cnt] = SD_address;
      acc_cnt++;
      idx = (SD_address - BASE) >> 2;
      b8  = idx[7:0];
      lat = (lat_mode == 0) ? lat_fixed : int'($urandom_range(1, 6));
      nd  = cyc + lat;
      if (nd <= last_due) nd = last_due + 1;
      last_due = nd;
      rq.push_back('{nd, {b8, b8 + 8'd1, b8 + 8'd2, 8'hAA}});
    end
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      SD_readdatavalid = 1'b1;
      SD_rdata = r.data;
    end else begin
      SD_readdatavalid = 1'b0;
      SD_rdata = 32'h0;
    end
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'b0;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (pix_valid && pix_ready) begin
      if (pop_cnt < 64) begin
        px[pop_cnt]   = {pix_r, pix_g, pix_b};
        px_l[pop_cnt] = pix_last;
      end
      pop_cnt++;
    end
    if (finished) fin_cnt++;
    if (acc_cnt - pop_cnt > max_inuse) max_inuse = acc_cnt - pop_cnt;
  end

  task automatic clear_logs();
    acc_cnt   = 0;
    pop_cnt   = 0;
    fin_cnt   = 0;
    max_inuse = 0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    clear_logs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (finished) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [33:0] act;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    act = {SD_read, SD_address, pix_valid, pix_last, busy, finished};
    checks++;
    if (act !== {1'b0, BASE, 4'b0000}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", act, {1'b0, BASE, 4'b0000});
    end
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({SD_read, busy, pix_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_release: got %b want 000", {SD_read, busy, pix_valid});
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [52:0] act, exp;
    ready_mode = 0; lat_mode = 0; lat_fixed = 3;
    start_frame();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise: got %b want 1", busy);
    end
    wait_done(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got finished_seen=%0d busy=%b want 1 0", ok, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fin_cnt, acc_cnt, pop_cnt} !== {32'd1, 32'(N), 32'(N)}) begin
      errors++;
      $display("FAIL single_counts: got fin=%0d acc=%0d pix=%0d want 1 %0d %0d",
               fin_cnt, acc_cnt, pop_cnt, N, N);
    end
    for (int i = 0; i < N; i++) begin
      act = {acc_addr[i], px[i], px_l[i]};
      exp = {BASE + 28'(4 * i), 8'(i), 8'(i + 1), 8'(i + 2), i == N - 1};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL single_pixel[%0d]: got %h want %h", i, act, exp);
      end
    end
    checks++;
    if (max_inuse > D) begin
      errors++;
      $display("FAIL single_credit: got %0d want <= %0d", max_inuse, D);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [52:0] act, exp;
    ready_mode = 1; lat_mode = 0; lat_fixed = 3;
    start_frame();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_last} !== {1'b1, 24'h000102, 1'b0}) begin
      errors++;
      $display("FAIL bp_head_early: got %h want %h",
               {pix_valid, pix_r, pix_g, pix_b, pix_last}, {1'b1, 24'h000102, 1'b0});
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_last} !== {1'b1, 24'h000102, 1'b0}) begin
      errors++;
      $display("FAIL bp_head_held: got %h want %h",
               {pix_valid, pix_r, pix_g, pix_b, pix_last}, {1'b1, 24'h000102, 1'b0});
    end
    checks++;
    if ({acc_cnt, pop_cnt, 31'd0, SD_read} !== {32'(D), 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL bp_credit_stop: got acc=%0d pix=%0d rd=%b want %0d 0 0",
               acc_cnt, pop_cnt, SD_read, D);
    end
    ready_mode = 0;
    wait_done(ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || fin_cnt != 1 || pop_cnt != N || max_inuse > D) begin
      errors++;
      $display("FAIL bp_complete: got ok=%0d fin=%0d pix=%0d inuse=%0d want 1 1 %0d <=%0d",
               ok, fin_cnt, pop_cnt, max_inuse, N, D);
    end
    for (int i = 0; i < N; i++) begin
      act = {acc_addr[i], px[i], px_l[i]};
      exp = {BASE + 28'(4 * i), 8'(i), 8'(i + 1), 8'(i + 2), i == N - 1};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL bp_pixel[%0d]: got %h want %h", i, act, exp);
      end
    end
  endtask

  task automatic test_wait_stall();
    bit ok;
    int stall_seen;
    int hits;
    ready_mode = 0; lat_mode = 0; lat_fixed = 3;
    stall_idx = 3; stall_left = 5;
    stall_seen = 0; ok = 1'b0;
    start_frame();
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (waitrequest) begin
        stall_seen++;
        checks++;
        if ({SD_read, SD_address} !== {1'b1, BASE + 28'hC}) begin
          errors++;
          $display("FAIL stall_hold: got %b %h want 1 %h", SD_read, SD_address, BASE + 28'hC);
        end
      end
      if (finished) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    hits = 0;
    for (int i = 0; i < N; i++) if (acc_addr[i] == BASE + 28'hC) hits++;
    checks++;
    if ({stall_seen, hits, acc_cnt} !== {32'd5, 32'd1, 32'(N)}) begin
      errors++;
      $display("FAIL stall_accept: got stalls=%0d hits=%0d acc=%0d want 5 1 %0d",
               stall_seen, hits, acc_cnt, N);
    end
    checks++;
    if (!ok || pop_cnt != N || px[N-1] !== 24'h0F1011 || fin_cnt != 1) begin
      errors++;
      $display("FAIL stall_frame: got ok=%0d pix=%0d last=%h fin=%0d want 1 %0d 0f1011 1",
               ok, pop_cnt, px[N-1], fin_cnt, N);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [52:0] act, exp;
    ready_mode = 0; lat_mode = 0; lat_fixed = 3;
    start_frame();
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (pop_cnt >= 8) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_progress: got pix=%0d want >= 8", pop_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({SD_read, SD_address, pix_valid, pix_last, busy, finished} !== {1'b0, BASE, 4'b0000}) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want %h",
               {SD_read, SD_address, pix_valid, pix_last, busy, finished}, {1'b0, BASE, 4'b0000});
    end
    @(negedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 100 && rq.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_valid, busy, SD_read} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_stale_ignored: got %b want 000", {pix_valid, busy, SD_read});
    end
    start_frame();
    wait_done(ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || fin_cnt != 1 || pop_cnt != N || acc_cnt != N) begin
      errors++;
      $display("FAIL midrst_restart: got ok=%0d fin=%0d pix=%0d acc=%0d want 1 1 %0d %0d",
               ok, fin_cnt, pop_cnt, acc_cnt, N, N);
    end
    for (int i = 0; i < N; i++) begin
      act = {acc_addr[i], px[i], px_l[i]};
      exp = {BASE + 28'(4 * i), 8'(i), 8'(i + 1), 8'(i + 2), i == N - 1};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL midrst_pixel[%0d]: got %h want %h", i, act, exp);
      end
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    ready_mode = 0; lat_mode = 0; lat_fixed = 3;
    start_frame();
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt >= N) ok = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (!ok || busy !== 1'b1 || SD_read !== 1'b0) begin
      errors++;
      $display("FAIL busy_drain_state: got ok=%0d busy=%b rd=%b want 1 1 0", ok, busy, SD_read);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(ok);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({fin_cnt, acc_cnt, pop_cnt} !== {32'd1, 32'(N), 32'(N)}) begin
      errors++;
      $display("FAIL busy_ignored_counts: got fin=%0d acc=%0d pix=%0d want 1 %0d %0d",
               fin_cnt, acc_cnt, pop_cnt, N, N);
    end
    checks++;
    if (!ok || {busy, SD_read, pix_valid} !== 3'b000) begin
      errors++;
      $display("FAIL busy_ignored_idle: got ok=%0d %b want 1 000", ok, {busy, SD_read, pix_valid});
    end
  endtask

  task automatic test_random();
    bit ok;
    int lasts;
    logic [52:0] act, exp;
    ready_mode = 2; lat_mode = 1;
    start_frame();
    wait_done(ok);
    repeat (3) @(posedge clk);
    #1;
    lasts = 0;
    for (int i = 0; i < N; i++) if (px_l[i]) lasts++;
    checks++;
    if (!ok || fin_cnt != 1 || pop_cnt != N || lasts != 1 || max_inuse > D) begin
      errors++;
      $display("FAIL rand_complete: got ok=%0d fin=%0d pix=%0d lasts=%0d inuse=%0d want 1 1 %0d 1 <=%0d",
               ok, fin_cnt, pop_cnt, lasts, max_inuse, N, D);
    end
    for (int i = 0; i < N; i++) begin
      act = {acc_addr[i], px[i], px_l[i]};
      exp = {BASE + 28'(4 * i), 8'(i), 8'(i + 1), 8'(i + 2), i == N - 1};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL rand_pixel[%0d]: got %h want %h", i, act, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_wait_stall();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_frame_reader.md
Name: sdram_frame_reader

Overview:
Avalon-MM pipelined read master that fetches one complete RGB frame from SDRAM. The frame is the one the output controller writes at base 0x8000000 with a 4-byte word stride. Each word is unpacked to 8-bit R/G/B and streamed out on a valid/ready pixel interface toward the display/scan-out path. A credit-limited pixel FIFO absorbs SDRAM read latency and downstream back-pressure.

Parameters:
PIXEL_COUNT, 307200, pixels per frame (640x480); one SDRAM word per pixel.
BASE_ADDR, 28'h8000000, byte address of pixel 0.
ADDR_STRIDE, 4, byte increment per pixel word.
FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4; also the cap on outstanding reads.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (reset == 0 resets)
start  in  1  one-cycle request to fetch a frame; ignored while busy
SD_read  out  1  Avalon read request
SD_address  out  28  Avalon byte address
waitrequest  in  1  slave stall; a read is accepted when SD_read && !waitrequest
SD_rdata  in  32  read data: [31:24]=R, [23:16]=G, [15:8]=B, [7:0] ignored
SD_readdatavalid  in  1  SD_rdata valid this cycle
pix_r  out  8  pixel red
pix_g  out  8  pixel green
pix_b  out  8  pixel blue
pix_valid  out  1  pixel available
pix_ready  in  1  consumer accepts; transfer when pix_valid && pix_ready
pix_last  out  1  qualifies the final pixel of the frame (valid only with pix_valid)
busy  out  1  high from the cycle after start acceptance until finished
finished  out  1  one-cycle pulse after the last pixel transfers

Behaviour:
- Reset values: SD_read=0, SD_address=BASE_ADDR, pix_valid=0, pix_last=0, busy=0, finished=0, FIFO empty, all counters 0, state IDLE.
- Reset mid-frame takes effect immediately. SD_read drops asynchronously, the FIFO and counters are cleared, and in-flight SDRAM responses arriving afterwards are discarded.
- Counters, each 19 bits:
  - issue_cnt: reads accepted.
  - rx_cnt: words received.
  - out_cnt: pixels transferred.
  - outstanding = issue_cnt - rx_cnt.
- Credit rule: SD_read may assert only if outstanding + fifo_count < FIFO_DEPTH. A readdatavalid can therefore never hit a full FIFO.
- Avalon rules:
  - Once SD_read is asserted, SD_read and SD_address are held stable while waitrequest=1.
  - On acceptance, SD_address += ADDR_STRIDE and issue_cnt += 1.
  - SD_read may stay high back-to-back (one read per cycle) while credits allow.
- States:
  - IDLE: on start, load SD_address=BASE_ADDR, clear counters, go to ISSUE. busy=1 from the next cycle. SD_readdatavalid in IDLE is ignored.
  - ISSUE: issue reads under the credit rule. When the acceptance making issue_cnt==PIXEL_COUNT occurs, drop SD_read on the next cycle and go to DRAIN.
  - DRAIN: no new reads. Keep accepting responses and streaming pixels. When the pixel with out_cnt==PIXEL_COUNT-1 transfers, go to DONE.
  - DONE: finished=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- Data path:
  - On SD_readdatavalid, push {SD_rdata[31:24],SD_rdata[23:16],SD_rdata[15:8]} into the FIFO; rx_cnt += 1.
  - The FIFO is show-ahead. pix_valid = !empty, and pix_r/g/b reflect the head entry.
  - Push-to-pix_valid latency is 1 cycle.
  - Simultaneous push and pop in one cycle is allowed; fifo_count is unchanged.
- pix_last = pix_valid && (out_cnt == PIXEL_COUNT-1).
- Outputs must hold while pix_valid && !pix_ready.
- start asserted while busy, or in the DONE cycle, is ignored; no frame is queued.
- Address wrap: 28-bit add wraps modulo 2^28. This is unreachable with default parameters (max address 0x812BFFC).

Decomposition:
- Shared package gpu_frame_pkg:
  - FRAME_PIXELS=307200.
  - FRAME_BASE_ADDR=28'h8000000.
  - SD_WORD_BYTES=4.
  - typedef rgb_t (packed r,g,b bytes).
  - State enum typedef {IDLE, ISSUE, DRAIN, DONE}.
- The output controller must also import the frame base/size constants from gpu_frame_pkg so both ends agree.
- One sub-module: pixel_fifo, a parameterised show-ahead synchronous FIFO of rgb_t. Ports: push, pop, data in/out, empty, full, count. Same clk and reset.

Test Plan:
1. Single frame, PIXEL_COUNT=8, waitrequest=0, fixed 3-cycle read latency, pix_ready=1, word i = {i,i+1,i+2,8'hAA}.
   - Addresses issued: 0x8000000..0x800001C.
   - Pixels received: r=i, g=i+1, b=i+2 in order; pix_last on i=7; finished pulses once.
2. Back-pressure: PIXEL_COUNT=64, FIFO_DEPTH=4, pix_ready=0 for 50 cycles, then 1.
   - outstanding+fifo_count never exceeds 4; no pixel is lost or duplicated; 64 pixels in order.
3. waitrequest stall: waitrequest=1 for 5 cycles at read 3.
   - SD_read and SD_address (0x800000C) are held stable throughout; exactly one acceptance for that address.
4. Reset mid-frame: assert reset=0 after 20 pixels, then release and start again.
   - All outputs return to reset values immediately; late readdatavalid is ignored; new frame restarts at 0x8000000 and out_cnt=0.
5. start while busy: pulse start during ISSUE and DRAIN.
   - No effect; exactly one finished pulse; issue_cnt ends at PIXEL_COUNT.
6. Default parameters, random latency 1-10, random pix_ready.
   - 307200 pixels; last address 0x812BFFC; pix_last only on the final transfer.
